// File: rtl/wb_stage_pkg.sv
// Shared types for the writeback stage: source select, load size and FSM state.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2,
    LS_D = 2'd3
  } load_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Combinational load-data extraction: shift by byte offset, slice by size, sign/zero-extend.
module wb_stage_load_extract
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_load_raw,
  input  logic [2:0]      i_addr_low,
  input  load_size_t      i_load_size,
  input  logic            i_load_unsigned,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_shift;
  logic            w_sx;

  assign w_shift = i_load_raw >> {i_addr_low, 3'b000};
  assign w_sx    = ~i_load_unsigned;

  always_comb begin
    o_result = w_shift;
    unique case (i_load_size)
      LS_B:    o_result = {{(XLEN-8){w_sx & w_shift[7]}},   w_shift[7:0]};
      LS_H:    o_result = {{(XLEN-16){w_sx & w_shift[15]}}, w_shift[15:0]};
      LS_W:    o_result = {{(XLEN-32){w_sx & w_shift[31]}}, w_shift[31:0]};
      LS_D:    o_result = w_shift;
      default: o_result = w_shift;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction, writes the regfile for one cycle,
// then waits for wb_finish to commit or for a timeout to raise a sticky err.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_rf_we,
  input  logic [4:0]      in_rd_addr,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_csr_rdata,
  input  logic [XLEN-1:0] in_load_raw,
  input  logic [1:0]      in_load_size,
  input  logic            in_load_unsigned,
  input  logic [2:0]      in_addr_low,
  output logic            RFwe,
  output logic [4:0]      rdaddr,
  output logic [XLEN-1:0] rd,
  output logic            wb_valid,
  input  logic            wb_finish,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [63:0]     commit_cnt,
  output logic            fwd_valid,
  output logic            err
);

  wb_state_t       r_state, w_state_nxt;
  logic            r_we;
  logic [4:0]      r_rdaddr;
  logic [XLEN-1:0] r_rd;
  logic [XLEN-1:0] r_pc;
  logic [7:0]      r_to_cnt;
  logic [63:0]     r_commit_cnt;
  logic            r_err;

  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_src;
  logic            w_capture;
  logic            w_commit;
  logic            w_timeout;
  logic            w_wr_en;

  wb_stage_load_extract #(.XLEN(XLEN)) u_load_extract (
    .i_load_raw      (in_load_raw),
    .i_addr_low      (in_addr_low),
    .i_load_size     (load_size_t'(in_load_size)),
    .i_load_unsigned (in_load_unsigned),
    .o_result        (w_load)
  );

  always_comb begin
    w_src = in_alu_result;
    unique case (wb_sel_t'(in_wb_sel))
      WB_ALU:  w_src = in_alu_result;
      WB_LOAD: w_src = w_load;
      WB_PC4:  w_src = in_pc + XLEN'(4);
      WB_CSR:  w_src = in_csr_rdata;
      default: w_src = in_alu_result;
    endcase
  end

  assign w_capture = (r_state == IDLE) && mem_valid;
  assign w_commit  = (r_state == WAIT) && wb_finish;
  // A finish in the last allowed WAIT cycle still commits rather than erroring.
  assign w_timeout = (r_state == WAIT) && !wb_finish && (r_to_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (mem_valid) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = WAIT;
      WAIT:    if (w_commit || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_rdaddr     <= 5'd0;
      r_rd         <= '0;
      r_pc         <= '0;
      r_to_cnt     <= 8'd0;
      r_commit_cnt <= 64'd0;
      r_err        <= 1'b0;
    end else begin
      if (w_capture) begin
        r_we     <= in_rf_we;
        r_rdaddr <= in_rd_addr;
        r_rd     <= w_src;
        r_pc     <= in_pc;
      end
      if (r_state == WAIT && !w_commit && !w_timeout) r_to_cnt <= r_to_cnt + 8'd1;
      else                                            r_to_cnt <= 8'd0;
      if (w_commit)  r_commit_cnt <= r_commit_cnt + 64'd1;
      if (w_timeout) r_err        <= 1'b1;
    end
  end

  assign w_wr_en      = r_we && (r_rdaddr != 5'd0);
  assign mem_ready    = (r_state == IDLE);
  assign wb_valid     = (r_state == WRITE);
  assign RFwe         = (r_state == WRITE) && w_wr_en;
  assign rdaddr       = r_rdaddr;
  assign rd           = r_rd;
  assign commit_valid = w_commit;
  assign commit_pc    = r_pc;
  assign commit_cnt   = r_commit_cnt;
  assign fwd_valid    = ((r_state == WRITE) || (r_state == WAIT)) && w_wr_en;
  assign err          = r_err;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes/commits, monitors pop and compare.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] in_pc;
  logic        in_rf_we;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [63:0] in_alu_result;
  logic [63:0] in_csr_rdata;
  logic [63:0] in_load_raw;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic [2:0]  in_addr_low;
  logic        RFwe;
  logic [4:0]  rdaddr;
  logic [63:0] rd;
  logic        wb_valid;
  logic        wb_finish;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] commit_cnt;
  logic        fwd_valid;
  logic        err;

  wb_stage #(.XLEN(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rd_addr(in_rd_addr), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_csr_rdata(in_csr_rdata), .in_load_raw(in_load_raw),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned), .in_addr_low(in_addr_low),
    .RFwe(RFwe), .rdaddr(rdaddr), .rd(rd), .wb_valid(wb_valid), .wb_finish(wb_finish),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_cnt(commit_cnt),
    .fwd_valid(fwd_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [4:0] addr; logic [63:0] data; } wr_t;
  typedef struct { logic [63:0] pc; logic [63:0] cnt; } cm_t;

  wr_t q_wr[$];
  cm_t q_cm[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          hs_cyc  = 0;
  logic [63:0] exp_cnt = 64'd0;
  logic        auto_fin = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Regfile model: wb_finish during the cycle after WRITE.
  initial begin
    logic f;
    forever begin
      @(negedge clk);
      f = wb_valid;
      @(posedge clk);
      #1;
      if (auto_fin) wb_finish = f;
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (q_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: addr %h data %h", rdaddr, rd);
        end else begin
          e = q_wr.pop_front();
          check("RFwe", {63'd0, RFwe}, {63'd0, e.we});
          check("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.we});
          check("rdaddr", {59'd0, rdaddr}, {59'd0, e.addr});
          check("rd", rd, e.data);
        end
      end
    end
  end

  initial begin
    cm_t e;
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) begin
        if (q_cm.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_commit: pc %h, expected no commit", commit_pc);
        end else begin
          e = q_cm.pop_front();
          check("commit_pc", commit_pc, e.pc);
          @(posedge clk);
          #1;
          check("commit_cnt", commit_cnt, e.cnt);
        end
      end
    end
  end

  task automatic issue(input logic [63:0] pc, input logic we, input logic [4:0] ra,
                       input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] csr,
                       input logic [63:0] raw, input logic [1:0] sz, input logic uns,
                       input logic [2:0] low, input logic [63:0] exp_rd, input logic exp_commit);
    wr_t w;
    cm_t c;
    int  n = 0;
    @(negedge clk);
    while (!mem_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ready) check("ready_timeout", {63'd0, mem_ready}, 64'd1);
    in_pc = pc; in_rf_we = we; in_rd_addr = ra; in_wb_sel = sel;
    in_alu_result = alu; in_csr_rdata = csr; in_load_raw = raw;
    in_load_size = sz; in_load_unsigned = uns; in_addr_low = low;
    mem_valid = 1'b1;
    w.we = we && (ra != 5'd0); w.addr = ra; w.data = exp_rd;
    q_wr.push_back(w);
    if (exp_commit) begin
      exp_cnt = exp_cnt + 64'd1;
      c.pc = pc; c.cnt = exp_cnt;
      q_cm.push_back(c);
    end
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    mem_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_RFwe"}, {63'd0, RFwe}, 64'd0);
    check({tag, "_rdaddr"}, {59'd0, rdaddr}, 64'd0);
    check({tag, "_rd"}, rd, 64'd0);
    check({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, "_commit_valid"}, {63'd0, commit_valid}, 64'd0);
    check({tag, "_commit_pc"}, commit_pc, 64'd0);
    check({tag, "_commit_cnt"}, commit_cnt, 64'd0);
    check({tag, "_fwd_valid"}, {63'd0, fwd_valid}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
    check({tag, "_mem_ready"}, {63'd0, mem_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    rst = 1'b1; mem_valid = 1'b0; wb_finish = 1'b0;
    in_pc = '0; in_rf_we = 1'b0; in_rd_addr = '0; in_wb_sel = '0;
    in_alu_result = '0; in_csr_rdata = '0; in_load_raw = '0;
    in_load_size = '0; in_load_unsigned = 1'b0; in_addr_low = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    //    pc                     we    rd     sel   alu            csr            raw                    sz    uns   low   exp_rd                 commit
    issue(64'h1000,              1'b1, 5'd5,  2'd0, 64'h1234,      64'h0,         64'h0,                 2'd0, 1'b0, 3'd0, 64'h1234,              1'b1);
    issue(64'h1004,              1'b1, 5'd6,  2'd1, 64'h0,         64'h0,         64'h0000_F000,         2'd0, 1'b0, 3'd1, 64'hFFFFFFFF_FFFFFFF0, 1'b1);
    issue(64'h1008,              1'b1, 5'd6,  2'd1, 64'h0,         64'h0,         64'h0000_F000,         2'd0, 1'b1, 3'd1, 64'hF0,                1'b1);
    issue(64'h100C,              1'b1, 5'd8,  2'd1, 64'h0,         64'h0,         64'h80000001_00000000, 2'd2, 1'b0, 3'd4, 64'hFFFFFFFF_80000001, 1'b1);
    issue(64'h1010,              1'b1, 5'd9,  2'd1, 64'h0,         64'h0,         64'h80000000_00000000, 2'd1, 1'b1, 3'd6, 64'h8000,              1'b1);
    issue(64'h1014,              1'b1, 5'd10, 2'd1, 64'h0,         64'h0,         64'h01234567_89ABCDEF, 2'd3, 1'b0, 3'd0, 64'h01234567_89ABCDEF, 1'b1);
    issue(64'h80000000,          1'b1, 5'd0,  2'd2, 64'h0,         64'h0,         64'h0,                 2'd0, 1'b0, 3'd0, 64'h80000004,          1'b1);
    issue(64'hFFFFFFFF_FFFFFFFC, 1'b1, 5'd1,  2'd2, 64'h0,         64'h0,         64'h0,                 2'd0, 1'b0, 3'd0, 64'h0,                 1'b1);
    issue(64'h2000,              1'b1, 5'd31, 2'd3, 64'h0,         64'hDEADBEEF,  64'h0,                 2'd0, 1'b0, 3'd0, 64'hDEADBEEF,          1'b1);
    c1 = hs_cyc;
    issue(64'h2004,              1'b0, 5'd7,  2'd0, 64'h55,        64'h0,         64'h0,                 2'd0, 1'b0, 3'd0, 64'h55,                1'b1);
    check("b2b_spacing", 64'(hs_cyc - c1), 64'd3);
    repeat (4) @(negedge clk);
    check("cnt_after_burst", commit_cnt, 64'd10);

    auto_fin = 1'b0;
    wb_finish = 1'b0;
    @(negedge clk);
    wb_finish = 1'b1;
    @(negedge clk);
    wb_finish = 1'b0;
    @(negedge clk);
    check("idle_finish_ignored", commit_cnt, exp_cnt);

    issue(64'h3000, 1'b1, 5'd3, 2'd0, 64'hABCD, 64'h0, 64'h0, 2'd0, 1'b0, 3'd0, 64'hABCD, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("err_before_timeout", {63'd0, err}, 64'd0);
    check("ready_in_wait", {63'd0, mem_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("err_at_timeout", {63'd0, err}, 64'd1);
    check("ready_after_timeout", {63'd0, mem_ready}, 64'd1);
    check("cnt_after_timeout", commit_cnt, exp_cnt);

    auto_fin = 1'b1;
    issue(64'h3004, 1'b1, 5'd4, 2'd0, 64'h77, 64'h0, 64'h0, 2'd0, 1'b0, 3'd0, 64'h77, 1'b1);
    repeat (3) @(negedge clk);
    check("err_sticky", {63'd0, err}, 64'd1);

    auto_fin = 1'b0;
    wb_finish = 1'b0;
    issue(64'h4000, 1'b1, 5'd12, 2'd0, 64'h99, 64'h0, 64'h0, 2'd0, 1'b0, 3'd0, 64'h99, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_in_wait");
    exp_cnt = 64'd0;
    @(negedge clk);
    rst = 1'b0;

    auto_fin = 1'b1;
    issue(64'h5000, 1'b1, 5'd2, 2'd0, 64'h42, 64'h0, 64'h0, 2'd0, 1'b0, 3'd0, 64'h42, 1'b1);
    repeat (5) @(negedge clk);
    check("cnt_after_reset", commit_cnt, 64'd1);
    check("wr_queue_empty", 64'(q_wr.size()), 64'd0);
    check("cm_queue_empty", 64'(q_cm.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
